ex_multicycle_unit: RTL and testbench

//  Iterative EX-stage arithmetic unit: unsigned shift-add multiply and restoring divide.
//  It is the source of the pipeline controller's ex_busy input and of the EX divide-by-zero

---
 rtl/ex_multicycle_unit.sv | 124 ++++++++++++
 tb/tb_ex_multicycle_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_multicycle_unit.sv
// Iterative EX-stage unit: unsigned shift-add multiply and restoring divide.
// One iteration per clock. Results are released to EX/MM as a single-cycle res_valid pulse.
module ex_multicycle_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic [3:0]       dst_in,
    input  logic             flush,
    output logic             ex_busy,
    output logic             div_zero,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [3:0]       dst_out
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   opd_q;      // multiplicand (MUL) or divisor (DIV)
    logic [2*WIDTH-1:0] acc_q;      // {hi, lo}: {product hi, multiplier} or {rem, quo}
    logic [CNT_W-1:0]   cnt_q;
    logic [3:0]         dst_q;
    logic               busy_q;
    logic               dz_q;
    logic               valid_q;
    logic [WIDTH-1:0]   res_lo_q;
    logic [WIDTH-1:0]   res_hi_q;
    logic [3:0]         dst_out_q;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_rem_ext;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] acc_d;
    logic               last_iter;

    // One iteration of the active operation.
    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    always_comb begin
        acc_d       = acc_q;
        mul_sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opd_q};
        div_rem_ext = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_trial   = div_rem_ext - {1'b0, opd_q};
        if (state_q == MUL) begin
            if (acc_q[0]) acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end else if (state_q == DIV) begin
            if (!div_trial[WIDTH]) acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else                   acc_d = {div_rem_ext[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // NOTE: state is updated with non-blocking assignments only. The datapath registers
    // (opd_q, acc_q, cnt_q, dst_q) are deliberately left out of reset: they are always
    // loaded at issue before being read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            dz_q      <= 1'b0;
            valid_q   <= 1'b0;
            res_lo_q  <= '0;
            res_hi_q  <= '0;
            dst_out_q <= 4'h0;
        end else begin
            dz_q    <= 1'b0;
            valid_q <= 1'b0;
            if (flush) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            opd_q <= op ? opb : opa;
                            acc_q <= {{WIDTH{1'b0}}, (op ? opa : opb)};
                            dst_q <= dst_in;
                            cnt_q <= '0;
                            if (!op) begin
                                state_q <= MUL;
                                busy_q  <= 1'b1;
                            end else if (opb != '0) begin
                                state_q <= DIV;
                                busy_q  <= 1'b1;
                            end else begin
                                dz_q <= 1'b1;
                            end
                        end
                    end
                    MUL, DIV: begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (last_iter) begin
                            state_q   <= DONE;
                            busy_q    <= 1'b0;
                            valid_q   <= 1'b1;
                            res_lo_q  <= acc_d[WIDTH-1:0];
                            res_hi_q  <= acc_d[2*WIDTH-1:WIDTH];
                            dst_out_q <= dst_q;
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ex_busy   = busy_q;
    assign div_zero  = dz_q;
    assign res_valid = valid_q;
    assign res_lo    = res_lo_q;
    assign res_hi    = res_hi_q;
    assign dst_out   = dst_out_q;

endmodule

// File: tb/tb_ex_multicycle_unit.sv
// Bench for ex_multicycle_unit: directed corner cases plus randomized ops checked against
// a behavioural model built from plain *, / and %.
module tb_ex_multicycle_unit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic [3:0]   dst_in;
    logic         flush;
    logic         ex_busy;
    logic         div_zero;
    logic         res_valid;
    logic [W-1:0] res_lo;
    logic [W-1:0] res_hi;
    logic [3:0]   dst_out;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] last_lo = '0;
    logic [W-1:0] last_hi = '0;
    logic [3:0]   last_dst = 4'h0;

    ex_multicycle_unit #(.WIDTH(W), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .opa       (opa),
        .opb       (opb),
        .dst_in    (dst_in),
        .flush     (flush),
        .ex_busy   (ex_busy),
        .div_zero  (div_zero),
        .res_valid (res_valid),
        .res_lo    (res_lo),
        .res_hi    (res_hi),
        .dst_out   (dst_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op and follow it to completion; flags are {ex_busy, res_valid, div_zero}.
    // With poke set, extra starts are driven during the busy window and in DONE.
    task automatic do_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] d, input bit poke);
        logic [2*W-1:0] p;
        logic [W-1:0]   el;
        logic [W-1:0]   eh;
        el = '0;
        eh = '0;
        if (!o) begin
            p  = (2*W)'(a) * (2*W)'(b);
            el = p[W-1:0];
            eh = p[2*W-1:W];
        end else if (b != '0) begin
            el = a / b;
            eh = a % b;
        end
        start  = 1'b1;
        op     = o;
        opa    = a;
        opb    = b;
        dst_in = d;
        tick();
        start  = 1'b0;
        opa    = W'($urandom);
        opb    = W'($urandom);
        dst_in = 4'($urandom);
        if (o && b == '0) begin
            check("dz_pulse", {ex_busy, res_valid, div_zero}, 3'b001);
            tick();
            check("dz_end", {ex_busy, res_valid, div_zero}, 3'b000);
            check("dz_hold_lo", res_lo, last_lo);
        end else begin
            for (int i = 1; i <= W; i++) begin
                check("busy", {ex_busy, res_valid, div_zero}, 3'b100);
                if (poke && i == 5) begin
                    start = 1'b1;
                    op    = ~o;
                end
                if (poke && i == 6) start = 1'b0;
                tick();
            end
            check("done_flags", {ex_busy, res_valid, div_zero}, 3'b010);
            check(o ? "quotient" : "prod_lo", res_lo, el);
            check(o ? "remainder" : "prod_hi", res_hi, eh);
            check("dst_out", dst_out, d);
            last_lo  = el;
            last_hi  = eh;
            last_dst = d;
            if (poke) begin
                start = 1'b1;
                op    = o;
                opb   = 16'h0001;
            end
            tick();
            start = 1'b0;
            check("after_done", {ex_busy, res_valid, div_zero}, 3'b000);
            check("hold_lo", res_lo, last_lo);
            check("hold_hi", res_hi, last_hi);
            check("hold_dst", dst_out, last_dst);
        end
    endtask

    initial begin
        logic         ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst    = 1'b1;
        start  = 1'b0;
        op     = 1'b0;
        flush  = 1'b0;
        opa    = '0;
        opb    = '0;
        dst_in = 4'h0;
        tick();
        start  = 1'b1;
        opa    = 16'h0003;
        opb    = 16'h0004;
        tick();
        start  = 1'b0;
        check("reset_flags", {ex_busy, res_valid, div_zero}, 3'b000);
        check("reset_lo", res_lo, 16'h0000);
        check("reset_hi", res_hi, 16'h0000);
        check("reset_dst", dst_out, 4'h0);
        rst = 1'b0;

        do_op(1'b0, 16'd7, 16'd9, 4'd3, 1'b0);
        do_op(1'b0, 16'hFFFF, 16'hFFFF, 4'd5, 1'b0);
        do_op(1'b0, 16'h0000, 16'h1234, 4'd6, 1'b0);
        do_op(1'b1, 16'd100, 16'd7, 4'd7, 1'b0);
        do_op(1'b1, 16'd5, 16'd9, 4'd8, 1'b0);
        do_op(1'b1, 16'hFFFF, 16'd1, 4'd9, 1'b0);
        do_op(1'b1, 16'd42, 16'd0, 4'd10, 1'b0);

        // Divide by zero with a simultaneous flush: no pulse at all.
        start = 1'b1; op = 1'b1; opa = 16'd42; opb = 16'd0; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        check("dz_flush", {ex_busy, res_valid, div_zero}, 3'b000);
        tick();
        check("dz_flush_after", {ex_busy, res_valid, div_zero}, 3'b000);

        // Flush a multiply mid-flight, then issue a divide right away.
        start = 1'b1; op = 1'b0; opa = 16'h1234; opb = 16'h5678; dst_in = 4'd11;
        tick();
        start = 1'b0;
        repeat (5) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_mid", {ex_busy, res_valid, div_zero}, 3'b000);
        check("flush_mid_hold", res_lo, last_lo);
        do_op(1'b1, 16'd1000, 16'd33, 4'd12, 1'b0);

        // Flush on the completing edge wins over completion.
        start = 1'b1; op = 1'b0; opa = 16'd3; opb = 16'd5; dst_in = 4'd2;
        tick();
        start = 1'b0;
        repeat (W - 1) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_last", {ex_busy, res_valid, div_zero}, 3'b000);
        check("flush_last_hold", res_lo, last_lo);
        tick();
        check("flush_last_after", {ex_busy, res_valid, div_zero}, 3'b000);

        // Reset in the middle of a divide abandons it.
        start = 1'b1; op = 1'b1; opa = 16'd5000; opb = 16'd3; dst_in = 4'd13;
        tick();
        start = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_flags", {ex_busy, res_valid, div_zero}, 3'b000);
        check("rst_mid_lo", res_lo, 16'h0000);
        check("rst_mid_hi", res_hi, 16'h0000);
        check("rst_mid_dst", dst_out, 4'h0);
        last_lo = '0; last_hi = '0; last_dst = 4'h0;
        for (int i = 0; i < W + 2; i++) begin
            check("rst_no_result", {ex_busy, res_valid, div_zero}, 3'b000);
            tick();
        end

        // Starts during busy and DONE must be ignored.
        do_op(1'b1, 16'd60000, 16'd123, 4'd14, 1'b1);
        do_op(1'b0, 16'd300, 16'd400, 4'd15, 1'b1);

        for (int n = 0; n < 40; n++) begin
            ro = 1'($urandom);
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? W'(0) :
                 ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 20)) : W'($urandom);
            do_op(ro, ra, rb, 4'($urandom), $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
